spi_byte_slave: RTL

//  SPI mode-0 slave physical layer between the external SPI pins and the systolic SPI

---
 rtl/spi_byte_slave_pkg.sv | 15 +
 rtl/spi_byte_slave_sync_edge_det.sv | 39 +++
 rtl/spi_byte_slave.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/spi_byte_slave_pkg.sv
// Shared definitions for the SPI byte slave: byte/counter widths, the default
// idle byte and the frame state type.
package spi_byte_slave_pkg;

  localparam int unsigned SPI_BYTE_W = 8;
  localparam int unsigned BIT_CNT_W  = 3;

  localparam logic [SPI_BYTE_W-1:0] IDLE_BYTE_DEF = 8'h00;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/spi_byte_slave_sync_edge_det.sv
// sync_edge_det: multi-stage synchronizer for an asynchronous pin followed by
// rise/fall detection on the synchronized level.
//  clk, rst_n : system clock, synchronous active-low reset
//  din        : asynchronous input pin
//  rise, fall : one-clk pulses, visible SYNC_STAGES clk after the pin change
//               and consumed by the next posedge (SYNC_STAGES+1 total)
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_byte_slave.sv
// spi_byte_slave: SPI mode-0 slave PHY. Oversamples sclk/mosi/cs_n in the clk
// domain, shifts received bytes MSB-first and serializes the transmit byte.
//  clk, rst_n         : system clock, synchronous active-low reset
//  sclk, mosi, cs_n   : SPI pins (asynchronous to clk)
//  miso               : SPI data out, 0 outside a frame
//  rx_data, rx_valid  : received byte and its one-clk strobe
//  tx_data, tx_valid  : byte offered for transmission
//  tx_ack             : pulse, tx_data taken at a load point
//  tx_underrun        : pulse, load point without tx_valid (IDLE_BYTE loaded)
//  frame_active       : synchronized, inverted cs_n
//  frame_abort        : pulse, cs_n released mid-byte
module spi_byte_slave
  import spi_byte_slave_pkg::*;
#(
  parameter int unsigned            SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0]  IDLE_BYTE   = IDLE_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs_n,
  output logic                  miso,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ack,
  output logic                  tx_underrun,
  output logic                  frame_active,
  output logic                  frame_abort
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // cs_n idles high: its falling edge opens a frame.
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // mosi chain has the same depth as the sclk chain so the sampled bit lines
  // up with the sclk_rise pulse.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  // Only the 7 oldest bits are ever needed: the 8th arrives with the strobe.
  logic [SPI_BYTE_W-2:0]  rx_sr_q, rx_sr_d;
  logic [SPI_BYTE_W-1:0]  tx_sr_q, tx_sr_d;
  logic                   load_pend_q, load_pend_d;
  logic [SPI_BYTE_W-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_ack_q, tx_ack_d;
  logic                   tx_underrun_q, tx_underrun_d;
  logic                   frame_active_q, frame_active_d;
  logic                   frame_abort_q, frame_abort_d;
  logic                   miso_q, miso_d;

  always_comb begin
    mosi_sync_d    = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_sr_d        = rx_sr_q;
    tx_sr_d        = tx_sr_q;
    load_pend_d    = load_pend_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    tx_ack_d       = 1'b0;
    tx_underrun_d  = 1'b0;
    frame_abort_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Load point A. A coincident sclk_rise is dropped because IDLE
        // never looks at sclk edges.
        if (cs_fall) begin
          state_d       = ST_ACTIVE;
          bit_cnt_d     = '0;
          rx_sr_d       = '0;
          load_pend_d   = 1'b0;
          tx_sr_d       = tx_valid ? tx_data : IDLE_BYTE;
          tx_ack_d      = tx_valid;
          tx_underrun_d = ~tx_valid;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d       = ST_IDLE;
          frame_abort_d = (bit_cnt_q != '0);
          bit_cnt_d     = '0;
          rx_sr_d       = '0;
          tx_sr_d       = '0;
          load_pend_d   = 1'b0;
        end else if (sclk_rise) begin
          rx_sr_d = {rx_sr_q[SPI_BYTE_W-3:0], mosi_s};
          if (bit_cnt_q == 3'd7) begin
            rx_data_d   = {rx_sr_q, mosi_s};
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            load_pend_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (sclk_fall) begin
          if (load_pend_q) begin
            // Load point B: first falling edge after a completed byte.
            load_pend_d   = 1'b0;
            tx_sr_d       = tx_valid ? tx_data : IDLE_BYTE;
            tx_ack_d      = tx_valid;
            tx_underrun_d = ~tx_valid;
          end else begin
            tx_sr_d = {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    frame_active_d = (state_d == ST_ACTIVE);
    // tx_sr is cleared at frame end, so the cycle that opens a frame still
    // drives 0 and the loaded MSB appears one clk later.
    miso_d = frame_active_d ? tx_sr_q[SPI_BYTE_W-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_sync_q    <= '0;
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      rx_sr_q        <= '0;
      tx_sr_q        <= '0;
      load_pend_q    <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      tx_ack_q       <= 1'b0;
      tx_underrun_q  <= 1'b0;
      frame_active_q <= 1'b0;
      frame_abort_q  <= 1'b0;
      miso_q         <= 1'b0;
    end else begin
      mosi_sync_q    <= mosi_sync_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_sr_q        <= rx_sr_d;
      tx_sr_q        <= tx_sr_d;
      load_pend_q    <= load_pend_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      tx_ack_q       <= tx_ack_d;
      tx_underrun_q  <= tx_underrun_d;
      frame_active_q <= frame_active_d;
      frame_abort_q  <= frame_abort_d;
      miso_q         <= miso_d;
    end
  end

  assign miso         = miso_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign tx_ack       = tx_ack_q;
  assign tx_underrun  = tx_underrun_q;
  assign frame_active = frame_active_q;
  assign frame_abort  = frame_abort_q;

endmodule
